// File: rtl/column_scheduler_if.sv
// column_scheduler_if
// Groups the signals between the game state machine / column instances and
// the column scheduler.
//   master : game side; drives game_run, score, col_cleared, col_bottom and
//            observes the scheduler outputs.
//   slave  : the scheduler; observes the game inputs and drives
//            col_active, spawn, spawn_letter, step, match_en, target_col, halt.
// Clock and reset are not part of the bundle; they stay plain module ports.
interface column_scheduler_if;
    logic       game_run;
    logic [7:0] score;
    logic [2:0] col_cleared;
    logic [2:0] col_bottom;
    logic [2:0] col_active;
    logic [2:0] spawn;
    logic [7:0] spawn_letter;
    logic [2:0] step;
    logic [2:0] match_en;
    logic [1:0] target_col;
    logic       halt;

    modport master (
        output game_run, score, col_cleared, col_bottom,
        input  col_active, spawn, spawn_letter, step, match_en, target_col, halt
    );

    modport slave (
        input  game_run, score, col_cleared, col_bottom,
        output col_active, spawn, spawn_letter, step, match_en, target_col, halt
    );
endinterface

// File: rtl/column_scheduler.sv
// column_scheduler
// Central timing for the three falling-letter columns: produces the fall-rate
// tick (period shrinks with score), spawns letters into free columns with a
// fixed number of ticks between spawns, and grants user-input matching to the
// oldest live letter only.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : column_scheduler_if.slave
//             in  game_run, score[7:0], col_cleared[2:0], col_bottom[2:0]
//             out col_active[2:0], spawn[2:0], spawn_letter[7:0], step[2:0],
//                 match_en[2:0], target_col[1:0], halt
module column_scheduler #(
    parameter int         NUM_COLS  = 3,
    parameter int         TICK_BASE = 12500000,
    parameter int         TICK_DEC  = 50000,
    parameter int         TICK_MIN  = 2500000,
    parameter int         SPAWN_GAP = 8,
    parameter logic [7:0] LFSR_SEED = 8'h5A
) (
    input logic              clock,
    input logic              reset_n,
    column_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int            SW  = $clog2(SPAWN_GAP + 1);
    localparam logic [SW-1:0] GAP = SW'(SPAWN_GAP);

    state_t              state_q, state_d;
    logic [31:0]         tick_cnt_q, tick_cnt_d;
    logic [31:0]         period_q, period_d;
    logic [SW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [NUM_COLS-1:0] col_active_q, col_active_d;
    // Age FIFO: entry 0 is the oldest live letter (the head).
    logic [1:0]          fifo_q [NUM_COLS];
    logic [1:0]          fifo_d [NUM_COLS];
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;

    logic [31:0]         score_dec;
    logic [31:0]         period_calc;
    logic                is_run;
    logic                bottom_hit;
    logic                advance;
    logic                wrap;
    logic                tick;
    logic [NUM_COLS-1:0] free_cols;
    logic [1:0]          free_idx;
    logic [NUM_COLS-1:0] spawn_mask;
    logic [SW-1:0]       gap_inc;
    logic                spawn_fire;
    logic [1:0]          head;
    logic                fifo_nonempty;
    logic                clear_fire;
    logic [NUM_COLS-1:0] clear_mask;
    logic                lfsr_fb;

    // Step period: max(TICK_MIN, TICK_BASE - score*TICK_DEC). Comparing the
    // decrement against the headroom avoids a negative intermediate.
    always_comb begin
        score_dec = 32'(bus.score) * 32'(TICK_DEC);
        if (score_dec > 32'(TICK_BASE - TICK_MIN)) begin
            period_calc = 32'(TICK_MIN);
        end else begin
            period_calc = 32'(TICK_BASE) - score_dec;
        end
    end

    // Lowest-index free column, taken from the pre-clear col_active so a
    // column freed this cycle is only reusable from the next tick on.
    always_comb begin
        free_cols = ~col_active_q;
        free_idx  = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (free_cols[i]) begin
                free_idx = 2'(i);
            end
        end
    end

    assign is_run        = (state_q == RUN);
    // A letter at the bottom stops the game before this cycle's tick/spawn.
    assign bottom_hit    = |(bus.col_bottom & col_active_q);
    assign advance       = is_run && bus.game_run && !bottom_hit;
    assign wrap          = (tick_cnt_q == (period_q - 32'd1));
    assign tick          = advance && wrap;
    assign gap_inc       = (gap_cnt_q == GAP) ? GAP : (gap_cnt_q + SW'(1));
    assign spawn_fire    = tick && (gap_inc == GAP) && (|free_cols);
    assign spawn_mask    = spawn_fire ? (NUM_COLS'(1) << free_idx) : '0;
    assign head          = fifo_q[0];
    assign fifo_nonempty = (fifo_cnt_q != 2'd0);
    // Only a clear on the head column counts; anything else is ignored.
    assign clear_fire    = is_run && bus.game_run && fifo_nonempty && bus.col_cleared[head];
    assign clear_mask    = clear_fire ? (NUM_COLS'(1) << head) : '0;
    assign lfsr_fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        period_d     = period_q;
        gap_cnt_d    = gap_cnt_q;
        lfsr_d       = lfsr_q;
        col_active_d = col_active_q;
        fifo_d       = fifo_q;
        fifo_cnt_d   = fifo_cnt_q;

        unique case (state_q)
            IDLE: begin
                tick_cnt_d   = '0;
                period_d     = period_calc;
                gap_cnt_d    = '0;
                col_active_d = '0;
                fifo_cnt_d   = '0;
                if (bus.game_run) begin
                    state_d   = RUN;
                    // Preloaded so the very first tick spawns.
                    gap_cnt_d = GAP;
                end
            end

            RUN: begin
                lfsr_d = {lfsr_q[6:0], lfsr_fb};
                if (!bus.game_run) begin
                    state_d      = IDLE;
                    tick_cnt_d   = '0;
                    gap_cnt_d    = '0;
                    col_active_d = '0;
                    fifo_cnt_d   = '0;
                end else begin
                    col_active_d = (col_active_q & ~clear_mask) | spawn_mask;

                    if (clear_fire) begin
                        for (int i = 0; i < NUM_COLS - 1; i++) begin
                            fifo_d[i] = fifo_q[i+1];
                        end
                        fifo_cnt_d = fifo_cnt_q - 2'd1;
                    end
                    // Push lands behind whatever survived the pop.
                    if (spawn_fire) begin
                        for (int i = 0; i < NUM_COLS; i++) begin
                            if (2'(i) == fifo_cnt_d) begin
                                fifo_d[i] = free_idx;
                            end
                        end
                        fifo_cnt_d = fifo_cnt_d + 2'd1;
                    end

                    if (bottom_hit) begin
                        state_d = HALT;
                    end else if (wrap) begin
                        tick_cnt_d = '0;
                        period_d   = period_calc;
                        gap_cnt_d  = spawn_fire ? '0 : gap_inc;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 32'd1;
                    end
                end
            end

            HALT: begin
                if (!bus.game_run) begin
                    state_d      = IDLE;
                    tick_cnt_d   = '0;
                    gap_cnt_d    = '0;
                    col_active_d = '0;
                    fifo_cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            period_q     <= 32'(TICK_BASE);
            gap_cnt_q    <= '0;
            lfsr_q       <= LFSR_SEED;
            col_active_q <= '0;
            fifo_cnt_q   <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            period_q     <= period_d;
            gap_cnt_q    <= gap_cnt_d;
            lfsr_q       <= lfsr_d;
            col_active_q <= col_active_d;
            fifo_cnt_q   <= fifo_cnt_d;
            for (int i = 0; i < NUM_COLS; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Step uses the pre-spawn col_active, so a new letter is not moved on
    // its spawn cycle.
    assign bus.col_active   = col_active_q;
    assign bus.step         = tick ? col_active_q : '0;
    assign bus.spawn        = spawn_mask;
    assign bus.spawn_letter = spawn_fire ? lfsr_q : 8'd0;
    assign bus.match_en     = (is_run && fifo_nonempty) ? (NUM_COLS'(1) << head) : '0;
    assign bus.target_col   = (is_run && fifo_nonempty) ? head : 2'd0;
    assign bus.halt         = (state_q == HALT);

endmodule

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler
// Drives column_scheduler with small timing parameters. A behavioural model
// (age order kept as a queue, active set derived from it, countdown to the
// next tick) predicts every output each cycle; scripted sections pin the
// model with hand-computed values.
module tb_column_scheduler;
    localparam int BASE = 20;
    localparam int DEC  = 1;
    localparam int MINP = 5;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    column_scheduler_if bus ();

    column_scheduler #(
        .NUM_COLS (3),
        .TICK_BASE(BASE),
        .TICK_DEC (DEC),
        .TICK_MIN (MINP),
        .SPAWN_GAP(GAP),
        .LFSR_SEED(8'h5A)
    ) dut (
        .clock  (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state;   // 0 idle, 1 run, 2 halt
    int         age[$];    // column indices, oldest first
    int         m_left;    // cycles left in current period, tick when 1
    int         m_gap;     // ticks since last spawn, saturating
    logic [7:0] m_lfsr;

    function automatic int mperiod(input int s);
        int p;
        p = BASE - s * DEC;
        return (p < MINP) ? MINP : p;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_cycle();
        logic [2:0] act, e_step, e_spawn, e_me;
        logic [7:0] e_let;
        logic [1:0] e_tgt;
        logic       run, bottom, tick, do_spawn;
        int         ng, free_col;
        if (!reset_n) begin
            m_state = 0; age.delete(); m_left = 0; m_gap = 0; m_lfsr = 8'h5A;
            chk("rst_active", 32'(bus.col_active), 0);
            chk("rst_spawn", 32'(bus.spawn), 0);
            chk("rst_step", 32'(bus.step), 0);
            chk("rst_match", 32'(bus.match_en), 0);
            chk("rst_target", 32'(bus.target_col), 0);
            chk("rst_letter", 32'(bus.spawn_letter), 0);
            chk("rst_halt", 32'(bus.halt), 0);
            return;
        end
        act = '0;
        foreach (age[i]) act[age[i]] = 1'b1;
        run    = (m_state == 1);
        bottom = run && ((bus.col_bottom & act) != 0);
        tick   = run && bus.game_run && !bottom && (m_left == 1);
        ng     = (m_gap + 1 > GAP) ? GAP : m_gap + 1;
        free_col = -1;
        for (int c = 2; c >= 0; c--) if (!act[c]) free_col = c;
        do_spawn = tick && (ng == GAP) && (free_col >= 0);
        e_step  = tick ? act : 3'b000;
        e_spawn = do_spawn ? 3'(1 << free_col) : 3'b000;
        e_let   = do_spawn ? m_lfsr : 8'h00;
        e_me    = (run && age.size() > 0) ? 3'(1 << age[0]) : 3'b000;
        e_tgt   = (run && age.size() > 0) ? 2'(age[0]) : 2'd0;

        chk("active", 32'(bus.col_active), 32'(act));
        chk("step", 32'(bus.step), 32'(e_step));
        chk("spawn", 32'(bus.spawn), 32'(e_spawn));
        chk("letter", 32'(bus.spawn_letter), 32'(e_let));
        chk("match_en", 32'(bus.match_en), 32'(e_me));
        chk("target", 32'(bus.target_col), 32'(e_tgt));
        chk("halt", 32'(bus.halt), 32'(m_state == 2));

        case (m_state)
            0: if (bus.game_run) begin
                m_state = 1; m_left = mperiod(int'(bus.score)); m_gap = GAP;
            end
            1: begin
                m_lfsr = lfsr_next(m_lfsr);
                if (!bus.game_run) begin
                    m_state = 0; age.delete();
                end else begin
                    if (age.size() > 0 && bus.col_cleared[age[0]]) void'(age.pop_front());
                    if (bottom) m_state = 2;
                    else if (tick) begin
                        m_left = mperiod(int'(bus.score));
                        m_gap  = do_spawn ? 0 : ng;
                        if (do_spawn) age.push_back(free_col);
                    end else m_left--;
                end
            end
            default: if (!bus.game_run) begin
                m_state = 0; age.delete();
            end
        endcase
    endtask

    initial forever begin
        @(negedge clk);
        model_cycle();
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [2:0] m);
        cyc(); bus.col_cleared = m;
        cyc(); bus.col_cleared = 3'b000;
        @(negedge clk);
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.step == 3'b000 && n < 100);
        chk("step_seen", 32'(bus.step != 3'b000), 1);
    endtask

    initial begin
        int         sp_k[$], st_k[$];
        logic [2:0] sp_v[$], st_v[$];
        int         bad_me, n;

        reset_n = 1'b0;
        bus.game_run = 1'b0; bus.score = 8'd0;
        bus.col_cleared = 3'b000; bus.col_bottom = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_active", 32'(bus.col_active), 0);
        chk("idle_halt", 32'(bus.halt), 0);

        // First spawns: ticks every 20 cycles, spawn every 2 ticks.
        cyc(); bus.game_run = 1'b1;
        bad_me = 0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (bus.spawn != 0) begin sp_k.push_back(k); sp_v.push_back(bus.spawn); end
            if (bus.step != 0) begin st_k.push_back(k); st_v.push_back(bus.step); end
            if (k > 21 && bus.match_en != 3'b001) bad_me++;
        end
        $display("[TB] script: spawns=%0d steps=%0d", sp_k.size(), st_k.size());
        chk("n_spawns", 32'(sp_k.size()), 3);
        chk("spawn0_cycle", 32'(sp_k[0]), 21);
        chk("spawn0_col", 32'(sp_v[0]), 3'b001);
        chk("spawn1_cycle", 32'(sp_k[1]), 61);
        chk("spawn1_col", 32'(sp_v[1]), 3'b010);
        chk("spawn2_cycle", 32'(sp_k[2]), 101);
        chk("spawn2_col", 32'(sp_v[2]), 3'b100);
        chk("step0_cycle", 32'(st_k[0]), 41);
        chk("step_period", 32'(st_k[1] - st_k[0]), 20);
        chk("step0_mask", 32'(st_v[0]), 3'b001);
        chk("step3_mask", 32'(st_v[3]), 3'b011);
        chk("match_head0", 32'(bad_me), 0);

        // Clear the head (column 0).
        do_clear(3'b001);
        $display("[TB] clear 001 -> active=%b match=%b", bus.col_active, bus.match_en);
        chk("clr_active", 32'(bus.col_active), 3'b110);
        chk("clr_match", 32'(bus.match_en), 3'b010);
        chk("clr_target", 32'(bus.target_col), 1);

        // Non-head clear ignored.
        do_clear(3'b100);
        $display("[TB] clear 100 (non-head) -> active=%b match=%b", bus.col_active, bus.match_en);
        chk("nonhead_active", 32'(bus.col_active), 3'b110);
        chk("nonhead_match", 32'(bus.match_en), 3'b010);

        // Next spawn refills column 0 at the FIFO tail.
        n = 0;
        do begin @(negedge clk); n++; end while (bus.spawn == 3'b000 && n < 100);
        chk("refill_spawn", 32'(bus.spawn), 3'b001);
        do_clear(3'b010);
        chk("order_after_1", 32'(bus.match_en), 3'b100);
        do_clear(3'b100);
        chk("order_after_2", 32'(bus.match_en), 3'b001);
        chk("order_target", 32'(bus.target_col), 0);

        // Period follows score from the next reload.
        cyc(); bus.score = 8'd255;
        wait_step(n);
        wait_step(n);
        $display("[TB] score=255 step interval=%0d", n);
        chk("period_clamp", 32'(n), 5);
        cyc(); bus.score = 8'd10;
        wait_step(n);
        wait_step(n);
        $display("[TB] score=10 step interval=%0d", n);
        chk("period_10", 32'(n), 10);

        // Halt on a bottomed active column.
        n = 0;
        do begin @(negedge clk); n++; end while (bus.col_active != 3'b111 && n < 300);
        chk("all_full", 32'(bus.col_active), 3'b111);
        cyc(); bus.col_bottom = 3'b010;
        cyc(); bus.col_bottom = 3'b000;
        @(negedge clk);
        $display("[TB] bottom 010 -> halt=%b step=%b match=%b", bus.halt, bus.step, bus.match_en);
        chk("halt_set", 32'(bus.halt), 1);
        chk("halt_match", 32'(bus.match_en), 0);
        repeat (30) @(negedge clk);
        chk("halt_frozen", 32'(bus.col_active), 3'b111);
        cyc(); bus.game_run = 1'b0;
        cyc();
        @(negedge clk);
        $display("[TB] game_run=0 -> halt=%b active=%b", bus.halt, bus.col_active);
        chk("to_idle_halt", 32'(bus.halt), 0);
        chk("to_idle_active", 32'(bus.col_active), 0);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (bus.halt) begin
                if ($urandom_range(0, 7) == 0) bus.game_run = 1'b0;
            end else if (!bus.game_run) begin
                if ($urandom_range(0, 3) == 0) bus.game_run = 1'b1;
            end else if ($urandom_range(0, 399) == 0) bus.game_run = 1'b0;
            if ($urandom_range(0, 49) == 0) bus.score = 8'($urandom_range(0, 255));
            bus.col_cleared = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            bus.col_bottom  = ($urandom_range(0, 299) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        end
        $display("[TB] random phase done, tests so far %0d", tests);

        // Asynchronous reset in the middle of play.
        bus.col_cleared = 3'b000; bus.col_bottom = 3'b000; bus.game_run = 1'b1; bus.score = 8'd0;
        repeat (60) cyc();
        reset_n = 1'b0;
        #1;
        $display("[TB] async reset -> active=%b halt=%b match=%b", bus.col_active, bus.halt, bus.match_en);
        chk("async_rst_active", 32'(bus.col_active), 0);
        chk("async_rst_match", 32'(bus.match_en), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cyc();
            bus.col_cleared = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 49) == 0) bus.score = 8'($urandom_range(0, 255));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
